// File: rtl/char_motion_pkg.sv
// Shared motion types and default geometry for the player sprite.
// Also used by the sprite drawer and collision logic.
package char_motion_pkg;

   typedef enum logic [1:0] {
      GROUNDED,
      RISING,
      FALLING
   } motion_state_e;

   localparam int Y_GROUND_DEF      = 60;
   localparam int X_START_DEF       = 72;
   localparam int JUMP_VELOCITY_DEF = 4;

endpackage

// File: rtl/character_jump_motion_if.sv
// Frame-tick controls in, sprite origin and air status out.
// master drives the controls; slave is the motion block.
interface character_jump_motion_if #(
   parameter int X_WIDTH = 8,
   parameter int Y_WIDTH = 7
) ();

   logic               enable;
   logic               jump;
   logic               left;
   logic               right;
   logic [X_WIDTH-1:0] x_position;
   logic [Y_WIDTH-1:0] y_position;
   logic               airborne;
   logic               landed;

   modport master (
      output enable, jump, left, right,
      input  x_position, y_position, airborne, landed
   );

   modport slave (
      input  enable, jump, left, right,
      output x_position, y_position, airborne, landed
   );

endinterface

// File: rtl/character_jump_motion_jump_edge_latch.sv
// Catches jump button presses between frame ticks.
// take includes a press arriving on the tick itself.
module jump_edge_latch (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic jump,
   output logic take
);

   logic jump_d;
   logic pending;

   assign take = pending | (jump & ~jump_d);

   always_ff @(posedge clock) begin
      if (reset) begin
         jump_d  <= 1'b0;
         pending <= 1'b0;
      end else begin
         jump_d  <= jump;
         pending <= enable ? 1'b0 : take;
      end
   end

endmodule

// File: rtl/character_jump_motion.sv
// Player sprite x/y per frame tick: clamped walking, jump with gravity.
// Define CHARACTER_DOUBLE_JUMP_EN to allow one extra jump per airtime.
module character_jump_motion
   import char_motion_pkg::*;
#(
   parameter int X_WIDTH       = 8,
   parameter int Y_WIDTH       = 7,
   parameter int X_START       = X_START_DEF,
   parameter int X_MIN         = 0,
   parameter int X_MAX         = 152,
   parameter int X_STEP        = 1,
   parameter int Y_GROUND      = Y_GROUND_DEF,
   parameter int Y_CEILING     = 0,
   parameter int JUMP_VELOCITY = JUMP_VELOCITY_DEF,
   parameter int GRAVITY_DIV   = 1,
   parameter int MAX_FALL      = 8,
   parameter int VEL_W         = 6
) (
   input logic                   clock,
   input logic                   reset,
   character_jump_motion_if.slave bus
);

   localparam int SW  = Y_WIDTH + 2;
   localparam int XW1 = X_WIDTH + 1;
   localparam int GW  = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

   localparam logic signed [SW-1:0] CEIL_S   = SW'(Y_CEILING);
   localparam logic signed [SW-1:0] GROUND_S = SW'(Y_GROUND);
   localparam logic signed [SW-1:0] JV_S     = SW'(JUMP_VELOCITY);

   localparam logic [Y_WIDTH-1:0] Y_G    = Y_WIDTH'(Y_GROUND);
   localparam logic [Y_WIDTH-1:0] Y_C    = Y_WIDTH'(Y_CEILING);
   localparam logic [Y_WIDTH-1:0] Y_JUMP = Y_WIDTH'(Y_GROUND - JUMP_VELOCITY);

   localparam logic signed [VEL_W-1:0] V_ZERO = '0;
   localparam logic signed [VEL_W-1:0] V_ONE  = VEL_W'(1);
   localparam logic signed [VEL_W-1:0] V_JUMP = VEL_W'(JUMP_VELOCITY);
   localparam logic signed [VEL_W-1:0] V_FALL = VEL_W'(-MAX_FALL);
   localparam logic signed [VEL_W-1:0] V_LAUNCH =
      (GRAVITY_DIV == 1) ? VEL_W'(JUMP_VELOCITY - 1) : V_JUMP;

   localparam logic [GW-1:0] G_LAST   = GW'(GRAVITY_DIV - 1);
   localparam logic [GW-1:0] G_LAUNCH = (GRAVITY_DIV == 1) ? '0 : GW'(1);

   localparam logic [XW1-1:0]     XMIN_W  = XW1'(X_MIN);
   localparam logic [XW1-1:0]     XMAX_W  = XW1'(X_MAX);
   localparam logic [XW1-1:0]     XSTEP_W = XW1'(X_STEP);
   localparam logic [X_WIDTH-1:0] XMIN_X  = X_WIDTH'(X_MIN);
   localparam logic [X_WIDTH-1:0] XMAX_X  = X_WIDTH'(X_MAX);
   localparam logic [X_WIDTH-1:0] XSTEP_X = X_WIDTH'(X_STEP);

   motion_state_e state_q, state_d;

   logic [X_WIDTH-1:0]      x_q, x_d;
   logic [Y_WIDTH-1:0]      y_q, y_d;
   logic signed [VEL_W-1:0] vel_q, vel_d, vel_g;
   logic [GW-1:0]           gc_q, gc_d, gc_g;
   logic                    landed_q, landed_d;
   logic                    take;
   logic                    dj_fire;
   logic signed [SW-1:0]    ny, ny_dj;
   logic [XW1-1:0]          x_sum;

`ifdef CHARACTER_DOUBLE_JUMP_EN
   logic dj_q, dj_d;
   assign dj_fire = take & ~dj_q;
`else
   assign dj_fire = 1'b0;
`endif

   jump_edge_latch u_edge (
      .clock  (clock),
      .reset  (reset),
      .enable (bus.enable),
      .jump   (bus.jump),
      .take   (take)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= GROUNDED;
         x_q      <= X_WIDTH'(X_START);
         y_q      <= Y_G;
         vel_q    <= V_ZERO;
         gc_q     <= '0;
         landed_q <= 1'b0;
`ifdef CHARACTER_DOUBLE_JUMP_EN
         dj_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vel_q    <= vel_d;
         gc_q     <= gc_d;
         landed_q <= landed_d;
`ifdef CHARACTER_DOUBLE_JUMP_EN
         dj_q     <= dj_d;
`endif
      end
   end

   // Gravity step taken on every airborne tick, overridden by ceiling/landing.
   always_comb begin
      gc_g  = gc_q + 1'b1;
      vel_g = vel_q;
      if (gc_q == G_LAST) begin
         gc_g  = '0;
         vel_g = (vel_q > V_FALL) ? vel_q - V_ONE : V_FALL;
      end
   end

   always_comb begin
      state_d  = state_q;
      y_d      = y_q;
      vel_d    = vel_q;
      gc_d     = gc_q;
      landed_d = 1'b0;
      ny       = $signed({2'b00, y_q}) - SW'(vel_q);
      ny_dj    = $signed({2'b00, y_q}) - JV_S;
`ifdef CHARACTER_DOUBLE_JUMP_EN
      dj_d     = dj_q;
`endif
      if (bus.enable) begin
         unique case (state_q)
            GROUNDED: begin
               if (take) begin
                  y_d     = Y_JUMP;
                  vel_d   = V_LAUNCH;
                  gc_d    = G_LAUNCH;
                  state_d = RISING;
               end
            end
            RISING, FALLING: begin
               if (dj_fire) begin
                  y_d     = (ny_dj <= CEIL_S) ? Y_C : ny_dj[Y_WIDTH-1:0];
                  vel_d   = V_JUMP;
                  gc_d    = '0;
                  state_d = RISING;
`ifdef CHARACTER_DOUBLE_JUMP_EN
                  dj_d    = 1'b1;
`endif
               end else if (vel_q > V_ZERO && ny <= CEIL_S) begin
                  // Only an upward move can bump; resting at the ceiling falls.
                  y_d     = Y_C;
                  vel_d   = V_ZERO;
                  gc_d    = gc_g;
                  state_d = FALLING;
               end else if (ny >= GROUND_S) begin
                  y_d      = Y_G;
                  vel_d    = V_ZERO;
                  gc_d     = '0;
                  state_d  = GROUNDED;
                  landed_d = 1'b1;
`ifdef CHARACTER_DOUBLE_JUMP_EN
                  dj_d     = 1'b0;
`endif
               end else begin
                  y_d     = ny[Y_WIDTH-1:0];
                  vel_d   = vel_g;
                  gc_d    = gc_g;
                  state_d = (vel_g > V_ZERO) ? RISING : FALLING;
               end
            end
            default: state_d = GROUNDED;
         endcase
      end
   end

   always_comb begin
      x_d   = x_q;
      x_sum = {1'b0, x_q} + XSTEP_W;
      if (bus.enable) begin
         if (bus.left && !bus.right) begin
            x_d = ({1'b0, x_q} < XMIN_W + XSTEP_W) ? XMIN_X : x_q - XSTEP_X;
         end else if (bus.right && !bus.left) begin
            x_d = (x_sum > XMAX_W) ? XMAX_X : x_sum[X_WIDTH-1:0];
         end
      end
   end

   assign bus.x_position = x_q;
   assign bus.y_position = y_q;
   assign bus.airborne   = (state_q != GROUNDED);
   assign bus.landed     = landed_q;

endmodule

// File: tb/tb_character_jump_motion.sv
// Random and directed stimulus on three parameterisations against a
// behavioural sprite-motion model; CHARACTER_DOUBLE_JUMP_EN aware.
module tb_character_jump_motion;

`ifdef CHARACTER_DOUBLE_JUMP_EN
   localparam bit DJ = 1'b1;
`else
   localparam bit DJ = 1'b0;
`endif

   localparam int N = 3;
   localparam int YG = 60;
   localparam int JV = 4;
   localparam int XMAX = 152;

   int p_xstart[N] = '{72, 150, 72};
   int p_xstep[N]  = '{1, 2, 1};
   int p_yceil[N]  = '{0, 55, 0};
   int p_gd[N]     = '{1, 1, 3};
   int p_mf[N]     = '{8, 8, 3};

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   character_jump_motion_if bus0 ();
   character_jump_motion_if bus1 ();
   character_jump_motion_if bus2 ();

   character_jump_motion dut0 (
      .clock (clock), .reset (reset), .bus (bus0.slave)
   );

   character_jump_motion #(
      .X_START (150), .X_STEP (2), .Y_CEILING (55)
   ) dut1 (
      .clock (clock), .reset (reset), .bus (bus1.slave)
   );

   character_jump_motion #(
      .GRAVITY_DIV (3), .MAX_FALL (3)
   ) dut2 (
      .clock (clock), .reset (reset), .bus (bus2.slave)
   );

   int ox[N], oy[N], oa[N], ol[N];
   assign ox[0] = int'(bus0.x_position);
   assign ox[1] = int'(bus1.x_position);
   assign ox[2] = int'(bus2.x_position);
   assign oy[0] = int'(bus0.y_position);
   assign oy[1] = int'(bus1.y_position);
   assign oy[2] = int'(bus2.y_position);
   assign oa[0] = int'(bus0.airborne);
   assign oa[1] = int'(bus1.airborne);
   assign oa[2] = int'(bus2.airborne);
   assign ol[0] = int'(bus0.landed);
   assign ol[1] = int'(bus1.landed);
   assign ol[2] = int'(bus2.landed);

   int errors = 0;
   int checks = 0;
   bit checking = 1'b0;

   // Model state: position, velocity, gravity phase, air/landing flags.
   int mx[N], my[N], mv[N], mg[N];
   bit mair[N], mland[N], mdj[N], mpend[N], mjd[N];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input int k, input bit rs, input bit en,
                             input bit j, input bit l, input bit r);
      bit take;
      int ny, nv, ng;
      if (rs) begin
         mx[k] = p_xstart[k]; my[k] = YG; mv[k] = 0; mg[k] = 0;
         mair[k] = 0; mland[k] = 0; mdj[k] = 0; mpend[k] = 0; mjd[k] = 0;
         return;
      end
      take = mpend[k] || (j && !mjd[k]);
      mjd[k] = j;
      mland[k] = 0;
      if (!en) begin
         mpend[k] = take;
         return;
      end
      mpend[k] = 0;
      if (l && !r) mx[k] = (mx[k] - p_xstep[k] < 0) ? 0 : mx[k] - p_xstep[k];
      if (r && !l) mx[k] = (mx[k] + p_xstep[k] > XMAX) ? XMAX : mx[k] + p_xstep[k];
      if (!mair[k]) begin
         if (take) begin
            my[k] = YG - JV;
            mv[k] = (p_gd[k] == 1) ? JV - 1 : JV;
            mg[k] = (p_gd[k] == 1) ? 0 : 1;
            mair[k] = 1;
         end
      end else if (DJ && take && !mdj[k]) begin
         mv[k] = JV;
         my[k] = (my[k] - JV <= p_yceil[k]) ? p_yceil[k] : my[k] - JV;
         mdj[k] = 1;
         mg[k] = 0;
      end else begin
         ny = my[k] - mv[k];
         ng = mg[k] + 1;
         nv = mv[k];
         if (ng == p_gd[k]) begin
            ng = 0;
            nv = (mv[k] - 1 < -p_mf[k]) ? -p_mf[k] : mv[k] - 1;
         end
         if (mv[k] > 0 && ny <= p_yceil[k]) begin
            my[k] = p_yceil[k]; mv[k] = 0; mg[k] = ng;
         end else if (ny >= YG) begin
            my[k] = YG; mv[k] = 0; mg[k] = 0;
            mair[k] = 0; mland[k] = 1; mdj[k] = 0;
         end else begin
            my[k] = ny; mv[k] = nv; mg[k] = ng;
         end
      end
   endtask

   task automatic cyc(input bit rs, input bit en, input bit j,
                      input bit l, input bit r);
      reset = rs;
      bus0.enable = en; bus0.jump = j; bus0.left = l; bus0.right = r;
      bus1.enable = en; bus1.jump = j; bus1.left = l; bus1.right = r;
      bus2.enable = en; bus2.jump = j; bus2.left = l; bus2.right = r;
      @(posedge clock);
      for (int k = 0; k < N; k++) model_step(k, rs, en, j, l, r);
      #1;
   endtask

   always @(negedge clock) begin
      if (checking) begin
         for (int k = 0; k < N; k++) begin
            chk($sformatf("x[%0d]", k), ox[k], mx[k]);
            chk($sformatf("y[%0d]", k), oy[k], my[k]);
            chk($sformatf("airborne[%0d]", k), oa[k], int'(mair[k]));
            chk($sformatf("landed[%0d]", k), ol[k], int'(mland[k]));
         end
      end
   end

   int exp0[9] = '{56, 53, 51, 50, 50, 51, 53, 56, 60};
   int exp1[6] = '{56, 55, 55, 56, 58, 60};

   initial begin
      bit j, l, r, en, prev_en;
      cyc(1, 0, 0, 0, 0);
      checking = 1'b1;

      // Idle ticks: reset position holds.
      for (int i = 0; i < 5; i++) begin
         cyc(0, 1, 0, 0, 0);
         cyc(0, 0, 0, 0, 0);
      end
      chk("idle_x", ox[0], 72);
      chk("idle_y", oy[0], 60);
      chk("idle_air", oa[0], 0);
      chk("idle_land", ol[0], 0);

      // Default jump arc; dut1 also bumps its ceiling at 55.
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 9; i++) begin
         cyc(0, 1, 1, 0, 0);
         chk($sformatf("arc_y%0d", i), oy[0], exp0[i]);
         chk($sformatf("arc_land%0d", i), ol[0], (i == 8) ? 1 : 0);
         chk($sformatf("arc_air%0d", i), oa[0], (i == 8) ? 0 : 1);
         if (i < 6) chk($sformatf("ceil_y%0d", i), oy[1], exp1[i]);
         cyc(0, 0, 1, 0, 0);
         if (i == 8) chk("land_pulse_end", ol[0], 0);
      end

      // Right walk clamps at X_MAX; both keys hold; left steps back.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 1);
      chk("walk_r0", ox[1], 152);
      cyc(0, 1, 0, 0, 1);
      chk("walk_r1", ox[1], 152);
      cyc(0, 1, 0, 1, 1);
      chk("walk_both", ox[1], 152);
      cyc(0, 1, 0, 1, 0);
      chk("walk_l", ox[1], 150);
      chk("walk_l_def", ox[0], 73);

      // Reset mid-jump.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
      chk("mid_y", oy[0], 51);
      cyc(1, 0, 0, 0, 0);
      chk("rst_y", oy[0], 60);
      chk("rst_air", oa[0], 0);
      chk("rst_land", ol[0], 0);

      // Airborne jump edges: ignored, or one double jump.
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("dj_pre", oy[0], 53);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("dj_second", oy[0], DJ ? 49 : 51);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);
      chk("dj_third", oy[0], DJ ? 45 : 50);

      // Randomised phase.
      j = 0; l = 0; r = 0; prev_en = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(3) == 0) j = ~j;
         if ($urandom_range(7) == 0) l = ~l;
         if ($urandom_range(7) == 0) r = ~r;
         en = !prev_en && ($urandom_range(2) == 0);
         prev_en = en;
         cyc($urandom_range(299) == 0, en, j, l, r);
      end

      checking = 1'b0;
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
